// File: rtl/status_flag_stack.sv
// Registered ALU condition flags {V,N,Z,C} with a small LIFO that saves and restores them.
// Stack misuse (push when full, pop when empty) sets a sticky error that CLR_ERR clears.
module status_flag_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       UPD,
  input  logic [3:0]                 MASK,
  input  logic                       IC,
  input  logic                       IV,
  input  logic [WIDTH-1:0]           DATA,
  input  logic                       PUSH,
  input  logic                       POP,
  input  logic                       CLR_ERR,
  output logic                       C,
  output logic                       Z,
  output logic                       N,
  output logic                       V,
  output logic [$clog2(DEPTH+1)-1:0] LEVEL,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       ERR
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    flags;
  logic [3:0]    flags_nxt;
  logic [3:0]    upd_val;
  logic [LW-1:0] level;
  logic [LW-1:0] level_nxt;
  logic          err;
  logic          full;
  logic          empty;
  logic          pop_ok;
  logic          push_ok;
  logic          err_evt;
  logic          stk_we;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;
  logic [3:0]    stk [2**IW];

  always_comb begin
    full    = (level == LW'(DEPTH));
    empty   = (level == '0);
    pop_ok  = POP && !empty;
    push_ok = PUSH && !POP && !full;
    err_evt = (PUSH && !POP && full) || (POP && empty);
    top_idx = IW'(level - LW'(1));
    upd_val = {IV, DATA[WIDTH-1], (DATA == '0), IC};

    // A pop (including the push+pop swap) owns the live flags; otherwise UPD applies.
    flags_nxt = flags;
    if (pop_ok)
      flags_nxt = stk[top_idx];
    else if (UPD)
      flags_nxt = (flags & ~MASK) | (upd_val & MASK);

    level_nxt = level;
    if (push_ok)
      level_nxt = level + LW'(1);
    else if (pop_ok && !PUSH)
      level_nxt = level - LW'(1);

    stk_we = push_ok || (pop_ok && PUSH);
    wr_idx = push_ok ? level[IW-1:0] : top_idx;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flags <= '0;
      level <= '0;
      err   <= 1'b0;
    end else begin
      flags <= flags_nxt;
      level <= level_nxt;
      if (err_evt)
        err <= 1'b1;
      else if (CLR_ERR)
        err <= 1'b0;
    end
  end

  // Entry storage carries no reset; entries at or above LEVEL are never read.
  always_ff @(posedge CLK) begin
    if (stk_we)
      stk[wr_idx] <= flags;
  end

  assign {V, N, Z, C} = flags;
  assign LEVEL        = level;
  assign FULL         = full;
  assign EMPTY        = empty;
  assign ERR          = err;

endmodule

// File: tb/tb_status_flag_stack.sv
// Bench for status_flag_stack: directed vector table, reset corner cases,
// then random traffic against a queue-based reference model.
module tb_status_flag_stack;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             UPD;
  logic [3:0]       MASK;
  logic             IC;
  logic             IV;
  logic [WIDTH-1:0] DATA;
  logic             PUSH;
  logic             POP;
  logic             CLR_ERR;
  logic             C, Z, N, V;
  logic [LW-1:0]    LEVEL;
  logic             FULL, EMPTY, ERR;

  int n_checks = 0;
  int n_pass   = 0;

  status_flag_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .UPD(UPD), .MASK(MASK), .IC(IC), .IV(IV),
    .DATA(DATA), .PUSH(PUSH), .POP(POP), .CLR_ERR(CLR_ERR),
    .C(C), .Z(Z), .N(N), .V(V), .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       upd;
    logic [3:0] mask;
    logic       ic;
    logic       iv;
    logic [3:0] data;
    logic       push;
    logic       pop;
    logic       clr;
    logic [3:0] ef;
    int         elvl;
    logic       eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic upd, logic [3:0] mask, logic ic, logic iv, logic [3:0] data,
                              logic push, logic pop, logic clr, logic [3:0] ef, int elvl, logic eerr);
    vec_t v;
    v.upd = upd; v.mask = mask; v.ic = ic; v.iv = iv; v.data = data;
    v.push = push; v.pop = pop; v.clr = clr;
    v.ef = ef; v.elvl = elvl; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic check_all(string name, logic [3:0] ef, int elvl, logic eerr);
    check({name, " flags"}, int'({V, N, Z, C}), int'(ef));
    check({name, " level"}, int'(LEVEL), elvl);
    check({name, " full"},  int'(FULL),  int'(elvl == DEPTH));
    check({name, " empty"}, int'(EMPTY), int'(elvl == 0));
    check({name, " err"},   int'(ERR),   int'(eerr));
  endtask

  task automatic drive(logic upd, logic [3:0] mask, logic ic, logic iv, logic [3:0] data,
                       logic push, logic pop, logic clr);
    UPD = upd; MASK = mask; IC = ic; IV = iv; DATA = data;
    PUSH = push; POP = pop; CLR_ERR = clr;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
    RST_N = 1'b0;
    tick();
    tick();
    #3;
    RST_N = 1'b1;
    tick();
  endtask

  // Reference model state
  logic [3:0] m_flags;
  logic       m_err;
  logic [3:0] m_q[$];

  task automatic model_step(logic upd, logic [3:0] mask, logic ic, logic iv, logic [3:0] data,
                            logic push, logic pop, logic clr);
    logic       evt;
    logic [3:0] fresh;
    logic [3:0] tmp;
    bit         restore;
    evt     = 0;
    restore = 0;
    fresh   = {iv, data[WIDTH-1], logic'(data == 0), ic};
    if (pop && m_q.size() == 0) evt = 1;
    else if (pop && push) begin
      tmp = m_q[m_q.size()-1];
      m_q[m_q.size()-1] = m_flags;
      m_flags = tmp;
      restore = 1;
    end else if (pop) begin
      m_flags = m_q.pop_back();
      restore = 1;
    end else if (push) begin
      if (m_q.size() == DEPTH) evt = 1;
      else m_q.push_back(m_flags);
    end
    if (!restore && upd)
      for (int b = 0; b < 4; b++) if (mask[b]) m_flags[b] = fresh[b];
    if (evt) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  initial begin
    drive(0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
    RST_N = 1'b0;
    #3;
    check_all("reset", 4'b0000, 0, 0);
    do_reset();
    check_all("after release", 4'b0000, 0, 0);

    //        upd mask   ic iv data    pu po cl   flags   lvl err
    tbl.push_back(mk(1, 4'hF,   1, 1, 4'b1000, 0, 0, 0, 4'b1101, 0, 0));
    tbl.push_back(mk(1, 4'b0010,0, 0, 4'b0000, 0, 0, 0, 4'b1111, 0, 0));
    tbl.push_back(mk(1, 4'hF,   1, 0, 4'b1000, 0, 0, 0, 4'b0101, 0, 0));
    tbl.push_back(mk(0, 4'h0,   0, 0, 4'b0000, 1, 0, 0, 4'b0101, 1, 0));
    tbl.push_back(mk(1, 4'hF,   0, 1, 4'b0000, 0, 0, 0, 4'b1010, 1, 0));
    tbl.push_back(mk(0, 4'h0,   0, 0, 4'b0000, 0, 1, 0, 4'b0101, 0, 0));
    tbl.push_back(mk(1, 4'hF,   0, 0, 4'b0000, 0, 1, 0, 4'b0010, 0, 1));
    tbl.push_back(mk(0, 4'h0,   0, 0, 4'b0000, 0, 0, 1, 4'b0010, 0, 0));
    tbl.push_back(mk(1, 4'hF,   0, 0, 4'b0001, 1, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(1, 4'hF,   1, 0, 4'b1000, 1, 0, 0, 4'b0101, 2, 0));
    tbl.push_back(mk(1, 4'hF,   1, 1, 4'b0000, 1, 0, 0, 4'b1011, 3, 0));
    tbl.push_back(mk(1, 4'hF,   0, 1, 4'b1111, 1, 0, 0, 4'b1100, 4, 0));
    tbl.push_back(mk(1, 4'b0001,1, 0, 4'b0000, 1, 0, 0, 4'b1101, 4, 1));
    tbl.push_back(mk(0, 4'h0,   0, 0, 4'b0000, 0, 0, 1, 4'b1101, 4, 0));
    tbl.push_back(mk(1, 4'hF,   0, 0, 4'b0000, 0, 1, 0, 4'b1011, 3, 0));
    tbl.push_back(mk(0, 4'h0,   0, 0, 4'b0000, 0, 1, 0, 4'b0101, 2, 0));
    tbl.push_back(mk(0, 4'h0,   0, 0, 4'b0000, 0, 1, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'h0,   0, 0, 4'b0000, 0, 1, 0, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 4'h0,   0, 0, 4'b0000, 0, 1, 1, 4'b0010, 0, 1));
    tbl.push_back(mk(0, 4'h0,   0, 0, 4'b0000, 0, 0, 1, 4'b0010, 0, 0));
    tbl.push_back(mk(1, 4'hF,   1, 0, 4'b0000, 0, 0, 0, 4'b0011, 0, 0));
    tbl.push_back(mk(0, 4'h0,   0, 0, 4'b0000, 1, 0, 0, 4'b0011, 1, 0));
    tbl.push_back(mk(1, 4'hF,   0, 1, 4'b1000, 0, 0, 0, 4'b1100, 1, 0));
    tbl.push_back(mk(1, 4'hF,   1, 1, 4'b0000, 1, 1, 0, 4'b0011, 1, 0));
    tbl.push_back(mk(0, 4'h0,   0, 0, 4'b0000, 0, 1, 0, 4'b1100, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].upd, tbl[i].mask, tbl[i].ic, tbl[i].iv, tbl[i].data,
            tbl[i].push, tbl[i].pop, tbl[i].clr);
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].ef, tbl[i].elvl, tbl[i].eerr);
    end

    // Asynchronous reset with LEVEL=3 and ERR=1, asserted between edges
    do_reset();
    drive(0, 4'h0, 0, 0, 4'h0, 0, 1, 0);
    tick();
    drive(1, 4'hF, 1, 1, 4'b1000, 1, 0, 0);
    tick();
    tick();
    tick();
    check_all("pre-reset", 4'b1101, 3, 1);
    #2;
    RST_N = 1'b0;
    #1;
    check_all("async reset", 4'b0000, 0, 0);
    tick();
    check_all("reset held over push", 4'b0000, 0, 0);
    #2;
    RST_N = 1'b1;
    drive(1, 4'hF, 1, 0, 4'b0000, 1, 0, 0);
    tick();
    check_all("first edge after release", 4'b0011, 1, 0);

    // Random traffic against the reference model
    do_reset();
    m_flags = 4'b0000;
    m_err   = 0;
    m_q.delete();
    for (int i = 0; i < 2000; i++) begin
      logic       r_upd, r_ic, r_iv, r_push, r_pop, r_clr;
      logic [3:0] r_mask, r_data;
      r_upd  = logic'($urandom_range(0, 1));
      r_mask = 4'($urandom);
      r_ic   = logic'($urandom_range(0, 1));
      r_iv   = logic'($urandom_range(0, 1));
      r_data = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      r_push = ($urandom_range(0, 2) == 0);
      r_pop  = ($urandom_range(0, 2) == 0);
      r_clr  = ($urandom_range(0, 7) == 0);
      drive(r_upd, r_mask, r_ic, r_iv, r_data, r_push, r_pop, r_clr);
      model_step(r_upd, r_mask, r_ic, r_iv, r_data, r_push, r_pop, r_clr);
      tick();
      check_all($sformatf("rand%0d", i), m_flags, m_q.size(), m_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/status_flag_stack.md
STATUS_FLAG_STACK -- requirements
Module: status_flag_stack

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the result-data width from which Z and N are derived (legal range 2..32).
REQ-002 Parameter DEPTH, default 4, SHALL set the number of flag-save stack entries (legal range 1..16).
REQ-003 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RST_N  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 UPD  input  1  SHALL be the flag-update enable.
REQ-006 MASK  input  4  SHALL be the per-flag write mask, with bits {V,N,Z,C} = [3:0].
REQ-007 IC  input  1  SHALL be the carry-in from the ALU.
REQ-008 IV  input  1  SHALL be the signed overflow from the ALU.
REQ-009 DATA  input  WIDTH  SHALL be the ALU result.
REQ-010 PUSH  input  1  SHALL save the current flags onto the stack.
REQ-011 POP  input  1  SHALL restore the flags from the stack top.
REQ-012 CLR_ERR  input  1  SHALL clear the sticky error flag.
REQ-013 C, Z, N, V  output  1 each  SHALL be the registered carry, zero, negative and overflow flags.
REQ-014 LEVEL  output  clog2(DEPTH+1)  SHALL be the stack occupancy.
REQ-015 FULL, EMPTY  output  1 each  SHALL mean LEVEL==DEPTH and LEVEL==0 respectively.
REQ-016 ERR  output  1  SHALL be a sticky flag for a stack overflow or underflow attempt.

Function
REQ-017 When UPD=1 and the flags are not being restored this cycle, each flag whose MASK bit is 1 SHALL load on the next edge:
- C from IC
- Z from (DATA==0)
- N from DATA[WIDTH-1]
- V from IV
REQ-018 Flags whose MASK bit is 0, and all flags when UPD=0, SHALL hold their value.
REQ-019 The flag outputs SHALL have 1-cycle latency from inputs to outputs and SHALL never be combinational from inputs.
REQ-020 PUSH alone with FULL=0 SHALL write the pre-edge {V,N,Z,C} to entry LEVEL and increment LEVEL.
- UPD SHALL still apply to the live flags in the same cycle.
REQ-021 POP alone with EMPTY=0 SHALL load all four flags from entry LEVEL-1, ignoring MASK, and decrement LEVEL.
- POP SHALL take precedence over UPD for the live flags.
REQ-022 PUSH and POP together with EMPTY=0 SHALL swap:
- live flags load the top entry
- the top entry loads the pre-edge flags
- LEVEL is unchanged
- UPD is ignored
REQ-023 PUSH with FULL=1 (POP=0) SHALL leave the stack and LEVEL unchanged, set ERR, and still apply UPD.
REQ-024 POP with EMPTY=1, with or without PUSH, SHALL leave the stack and LEVEL unchanged, set ERR, and still apply UPD.
REQ-025 ERR SHALL stay 1 until a cycle with CLR_ERR=1.
- If an error event and CLR_ERR occur in the same cycle, ERR SHALL end at 1.
REQ-026 FULL and EMPTY SHALL be decoded from the registered LEVEL.
REQ-027 Stack entries at index >= LEVEL SHALL not be observable; their contents are don't-care.

Reset
REQ-028 RST_N=0 SHALL immediately, without waiting for a clock edge, force C=Z=N=V=0, LEVEL=0, EMPTY=1, FULL=0 and ERR=0.
REQ-029 Stack entry contents SHALL NOT require reset.
REQ-030 A reset asserted mid-operation SHALL discard any push or pop in progress on that edge.
REQ-031 Deassertion of RST_N SHALL be followed by normal operation from the first rising edge after release.

Verification
REQ-032 Update: WIDTH=4, UPD=1, MASK=4'hF, DATA=4'b1000, IC=1, IV=1 -> next cycle C=1, Z=0, N=1, V=1; then DATA=0, MASK=4'b0010 -> Z=1 and C, N, V unchanged.
REQ-033 Push/pop: flags {V,N,Z,C}=0101, PUSH -> LEVEL=1; update flags to 1010, then POP -> flags 0101, LEVEL=0, EMPTY=1.
REQ-034 Full: DEPTH=4, PUSH for 5 cycles -> LEVEL=4, FULL=1, ERR=1 after the 5th push; CLR_ERR -> ERR=0; stack contents intact on 4 pops in LIFO order.
REQ-035 Underflow and same-cycle update: POP with EMPTY=1 and UPD=1, MASK=4'hF, DATA=0 -> ERR=1, Z=1, LEVEL=0.
REQ-036 Swap: LEVEL=1 with top=0011 and live=1100; PUSH and POP together -> live=0011, top=1100, LEVEL=1.
REQ-037 Reset: RST_N pulled low between clock edges with LEVEL=3, ERR=1 -> all outputs at reset values before the next edge.
